// File: rtl/gpio_input_debounce_if.sv
// Signal bundle between a raw board input, its debouncer, and the fabric
// logic that consumes the debounced level, edge pulses and event count.
interface gpio_input_debounce_if #(
  parameter int EVT_WIDTH = 16
);
  logic                 raw_in;
  logic                 clear_count;
  logic                 level_out;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [EVT_WIDTH-1:0] event_count;

  modport master (
    output raw_in, clear_count,
    input  level_out, rise_pulse, fall_pulse, event_count
  );

  modport slave (
    input  raw_in, clear_count,
    output level_out, rise_pulse, fall_pulse, event_count
  );
endinterface

// File: rtl/gpio_input_debounce.sv
// Debounces one asynchronous board input for a read-only GPIO PIO: two-flop
// synchronizer, counter-based accept FSM, edge pulses and a rising-edge counter.
module gpio_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DBC_WIDTH       = 16,
  parameter int EVT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpio_input_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_t;

  // The entry cycle is not part of the run, so the counter stops at N-1.
  localparam logic [DBC_WIDTH-1:0] LAST = DBC_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync_q;
  state_t               state;
  logic [DBC_WIDTH-1:0] dbc_cnt;
  logic                 level;
  logic                 rise;
  logic                 fall;
  logic [EVT_WIDTH-1:0] evt_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync_q  <= 1'b0;
      state   <= STABLE_LOW;
      dbc_cnt <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      evt_cnt <= '0;
    end else begin
      sync1  <= bus.raw_in;
      sync_q <= sync1;
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (bus.clear_count) evt_cnt <= '0;

      case (state)
        STABLE_LOW: begin
          if (sync_q) begin
            state   <= CHECK_HIGH;
            dbc_cnt <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!sync_q) begin
            state   <= STABLE_LOW;
            dbc_cnt <= '0;
          end else if (dbc_cnt == LAST) begin
            state <= STABLE_HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
            // A clear coinciding with an accepted rise keeps that rise.
            evt_cnt <= bus.clear_count ? EVT_WIDTH'(1) : evt_cnt + EVT_WIDTH'(1);
          end else begin
            dbc_cnt <= dbc_cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!sync_q) begin
            state   <= CHECK_LOW;
            dbc_cnt <= '0;
          end
        end
        CHECK_LOW: begin
          if (sync_q) begin
            state   <= STABLE_HIGH;
            dbc_cnt <= '0;
          end else if (dbc_cnt == LAST) begin
            state <= STABLE_LOW;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            dbc_cnt <= dbc_cnt + 1'b1;
          end
        end
        default: begin
          state   <= STABLE_LOW;
          dbc_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.level_out   = level;
  assign bus.rise_pulse  = rise;
  assign bus.fall_pulse  = fall;
  assign bus.event_count = evt_cnt;

endmodule
